// File: rtl/conv_pkg.sv
// conv_pkg: shared types and helpers for the KxK streaming convolution engine.
//   conv_state_e : controller states (IDLE, LOAD_W, ACCUM, OUT)
//   acc_width()  : accumulator width that exactly bounds a TAPS-term dot product
package conv_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD_W = 2'd1,
    ACCUM  = 2'd2,
    OUT    = 2'd3
  } conv_state_e;

  // A product needs 2*data_w bits; summing taps of them grows by clog2(taps).
  function automatic int acc_width(input int data_w, input int taps);
    return 2 * data_w + $clog2(taps);
  endfunction

endpackage

// File: rtl/conv_mac.sv
// conv_mac: single multiply-accumulate datapath.
//   clk, rst   : clock, synchronous active-high reset (clears accumulator)
//   clr_i      : clear accumulator
//   load_i     : acc <= a*b   (first tap of a window)
//   en_i       : acc <= acc + a*b
//   a_i, b_i   : operands, signed or unsigned per SIGNED
//   sum_o      : value the accumulator takes on a load/enable (used for the
//                final tap so the result is ready without an extra cycle)
module conv_mac #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 20,
  parameter int SIGNED = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_i,
  input  logic              load_i,
  input  logic              en_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic [ACC_W-1:0]  sum_o
);

  localparam int PW = 2 * DATA_W;

  logic [ACC_W-1:0] prod_ext;
  logic [ACC_W-1:0] acc_q;

  generate
    if (SIGNED != 0) begin : g_signed
      logic signed [PW-1:0] prod;
      assign prod     = PW'($signed(a_i)) * PW'($signed(b_i));
      assign prod_ext = ACC_W'(prod);      // sign-extends
    end else begin : g_unsigned
      logic [PW-1:0] prod;
      assign prod     = PW'(a_i) * PW'(b_i);
      assign prod_ext = ACC_W'(prod);      // zero-extends
    end
  endgenerate

  assign sum_o = load_i ? prod_ext : acc_q + prod_ext;

  always_ff @(posedge clk) begin
    if (rst || clr_i)  acc_q <= '0;
    else if (load_i)   acc_q <= prod_ext;
    else if (en_i)     acc_q <= sum_o;
  end

endmodule

// File: rtl/conv_kxk_stream.sv
// conv_kxk_stream: KxK convolution engine with a resident weight buffer.
// Weights are loaded serially once (raster order), then IFM windows stream one
// tap per cycle through a single MAC; each dot product leaves on out_valid/ready.
//   clk, rst_n          : clock; rst_n is a synchronous ACTIVE-HIGH reset
//   w_valid/w_ready/w_data     : weight beat handshake
//   wt_loaded           : full weight set resident
//   in_valid/in_ready/in_data  : IFM tap handshake
//   out_valid/out_ready/out_data : result handshake (out_data is 0 when idle)
// Optional feature macro: CONV_RELU_EN (clamp negative results to 0, SIGNED=1).
module conv_kxk_stream
  import conv_pkg::*;
#(
  parameter  int DATA_W = 8,
  parameter  int KSIZE  = 3,
  parameter  int SIGNED = 0,
  localparam int TAPS   = KSIZE * KSIZE,
  localparam int ACC_W  = acc_width(DATA_W, TAPS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              w_valid,
  output logic              w_ready,
  input  logic [DATA_W-1:0] w_data,
  output logic              wt_loaded,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_data
);

  localparam int                CNT_W = (TAPS > 1) ? $clog2(TAPS) : 1;
  localparam logic [CNT_W-1:0]  LAST  = CNT_W'(TAPS - 1);
  localparam logic [CNT_W-1:0]  ONE   = CNT_W'(1);

  conv_state_e                   state_q;
  logic [CNT_W-1:0]              w_cnt_q, tap_cnt_q;
  logic [TAPS-1:0][DATA_W-1:0]   wbuf_q;
  logic                          wt_loaded_q, out_valid_q;
  logic [ACC_W-1:0]              out_data_q;

  logic              w_fire, in_fire;
  logic [DATA_W-1:0] w_sel;
  logic [ACC_W-1:0]  sum, res;

  // Weights have priority over IFM taps when both are offered in IDLE.
  always_comb begin
    w_ready  = (state_q == IDLE) || (state_q == LOAD_W);
    in_ready = ((state_q == IDLE) && wt_loaded_q && !w_valid) || (state_q == ACCUM);
  end

  assign w_fire  = w_valid && w_ready;
  assign in_fire = in_valid && in_ready;

  // Tap 0 is always taken in IDLE, later taps in ACCUM.
  assign w_sel = (state_q == ACCUM) ? wbuf_q[tap_cnt_q] : wbuf_q[0];

  conv_mac #(.DATA_W(DATA_W), .ACC_W(ACC_W), .SIGNED(SIGNED)) u_mac (
    .clk   (clk),
    .rst   (rst_n),
    .clr_i (state_q == OUT),
    .load_i(in_fire && (state_q == IDLE)),
    .en_i  (in_fire && (state_q == ACCUM)),
    .a_i   (in_data),
    .b_i   (w_sel),
    .sum_o (sum)
  );

  always_comb begin
    res = sum;
`ifdef CONV_RELU_EN
    if ((SIGNED != 0) && sum[ACC_W-1]) res = '0;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q     <= IDLE;
      w_cnt_q     <= '0;
      tap_cnt_q   <= '0;
      wbuf_q      <= '0;
      wt_loaded_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (w_fire) begin
            wbuf_q[0]   <= w_data;
            wt_loaded_q <= (TAPS == 1);
            w_cnt_q     <= ONE;
            state_q     <= (TAPS == 1) ? IDLE : LOAD_W;
          end else if (in_fire) begin
            if (TAPS == 1) begin
              out_data_q  <= res;
              out_valid_q <= 1'b1;
              state_q     <= OUT;
            end else begin
              tap_cnt_q <= ONE;
              state_q   <= ACCUM;
            end
          end
        end
        LOAD_W: begin
          if (w_fire) begin
            wbuf_q[w_cnt_q] <= w_data;
            w_cnt_q         <= w_cnt_q + ONE;
            if (w_cnt_q == LAST) begin
              wt_loaded_q <= 1'b1;
              w_cnt_q     <= '0;
              state_q     <= IDLE;
            end
          end
        end
        ACCUM: begin
          if (in_fire) begin
            tap_cnt_q <= tap_cnt_q + ONE;
            if (tap_cnt_q == LAST) begin
              out_data_q  <= res;
              out_valid_q <= 1'b1;
              tap_cnt_q   <= '0;
              state_q     <= OUT;
            end
          end
        end
        OUT: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign wt_loaded = wt_loaded_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_conv_kxk_stream.sv
module tb_conv_kxk_stream;

  localparam int DW = 8;
  localparam int AW = 20;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          w_valid, in_valid, out_ready;
  logic [DW-1:0] w_data, in_data;
  logic          w_ready, in_ready, wt_loaded, out_valid;
  logic [AW-1:0] out_data;
  logic          s_w_ready, s_in_ready, s_wt_loaded, s_out_valid;
  logic [AW-1:0] s_out_data;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  conv_kxk_stream #(.DATA_W(DW), .KSIZE(3), .SIGNED(0)) dut (
    .clk(clk), .rst_n(rst_n),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data), .wt_loaded(wt_loaded),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );

  // Signed instance sees the same stimulus; its control flow is identical.
  conv_kxk_stream #(.DATA_W(DW), .KSIZE(3), .SIGNED(1)) dut_s (
    .clk(clk), .rst_n(rst_n),
    .w_valid(w_valid), .w_ready(s_w_ready), .w_data(w_data), .wt_loaded(s_wt_loaded),
    .in_valid(in_valid), .in_ready(s_in_ready), .in_data(in_data),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_data(s_out_data)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_w(input logic [DW-1:0] d);
    int n;
    n = 0;
    w_valid = 1'b1; w_data = d;
    @(negedge clk);
    while (!w_ready && n < 40) begin @(negedge clk); n++; end
    if (!w_ready) chk("w_ready_timeout", 32'(w_ready), 32'd1);
    @(posedge clk); #1;
    w_valid = 1'b0;
  endtask

  task automatic send_in(input logic [DW-1:0] d);
    int n;
    n = 0;
    in_valid = 1'b1; in_data = d;
    @(negedge clk);
    while (!in_ready && n < 40) begin @(negedge clk); n++; end
    if (!in_ready) chk("in_ready_timeout", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic load_w(input int start, input int inc, input int cnt);
    logic [DW-1:0] w;
    for (int i = 0; i < cnt; i++) begin
      w = DW'(start + i * inc);
      send_w(w);
    end
  endtask

  // Returns in the cycle after the last tap is accepted.
  task automatic window(input logic [DW-1:0] d, input bit bubble);
    for (int i = 0; i < 9; i++) begin
      send_in(d);
      if (bubble && i < 8) begin @(posedge clk); #1; end
    end
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b1; w_valid = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    w_data = '0; in_data = '0;
    cyc(); cyc();
    rst_n = 1'b0;

    // Reset values
    @(negedge clk);
    chk("rst_w_ready",   32'(w_ready),   32'd1);
    chk("rst_in_ready",  32'(in_ready),  32'd0);
    chk("rst_wt_loaded", 32'(wt_loaded), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data",  32'(out_data),  32'd0);
    cyc();

    // Weights 1..9, IFM all 1 -> 45
    load_w(1, 1, 9);
    @(negedge clk);
    chk("t1_wt_loaded", 32'(wt_loaded), 32'd1);
    chk("t1_in_ready_after_load", 32'(in_ready), 32'd1);
    cyc();
    window(8'd1, 1'b0);
    @(negedge clk);
    chk("t1_out_valid",  32'(out_valid),  32'd1);
    chk("t1_out_data",   32'(out_data),   32'd45);
    chk("t1_s_out_data", 32'(s_out_data), 32'd45);
    chk("t1_in_ready_in_out", 32'(in_ready), 32'd0);
    cyc();
    @(negedge clk);
    chk("t1_in_ready_next",  32'(in_ready),  32'd1);
    chk("t1_out_valid_drop", 32'(out_valid), 32'd0);
    chk("t1_out_data_zero",  32'(out_data),  32'd0);
    cyc();

    // All 255 -> 585225, no wrap
    load_w(255, 0, 9);
    window(8'd255, 1'b0);
    @(negedge clk);
    chk("t2_out_data", 32'(out_data), 32'h8EE09);
    cyc(); cyc();

    // Back-pressure: hold out_ready low for 5 cycles in OUT
    load_w(1, 1, 9);
    out_ready = 1'b0;
    window(8'd1, 1'b0);
    in_valid = 1'b1; in_data = 8'd7;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t3_hold_valid",    32'(out_valid), 32'd1);
      chk("t3_hold_data",     32'(out_data),  32'd45);
      chk("t3_hold_in_ready", 32'(in_ready),  32'd0);
      chk("t3_hold_w_ready",  32'(w_ready),   32'd0);
      cyc();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    cyc();
    @(negedge clk);
    chk("t3_released", 32'(out_valid), 32'd0);
    cyc();
    window(8'd2, 1'b0);
    @(negedge clk);
    chk("t3_win2_data", 32'(out_data), 32'd90);
    cyc(); cyc();

    // Bubbles between every tap
    window(8'd1, 1'b1);
    @(negedge clk);
    chk("t4_bubble_data", 32'(out_data), 32'd45);
    cyc(); cyc();

    // Simultaneous weight + IFM offer in IDLE: weight wins
    w_valid = 1'b1; w_data = 8'd1; in_valid = 1'b1; in_data = 8'd3;
    @(negedge clk);
    chk("t4_simul_in_ready", 32'(in_ready), 32'd0);
    chk("t4_simul_w_ready",  32'(w_ready),  32'd1);
    cyc();
    w_valid = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("t4_wt_loaded_drop", 32'(wt_loaded), 32'd0);
    chk("t4_load_in_ready",  32'(in_ready),  32'd0);
    cyc();
    load_w(2, 1, 8);
    window(8'd1, 1'b0);
    @(negedge clk);
    chk("t4_after_reload", 32'(out_data), 32'd45);
    cyc(); cyc();

    // Signed: weights -1, IFM 2 -> -18 (0 with ReLU); unsigned sees 255*2*9
    load_w(255, 0, 9);
    window(8'd2, 1'b0);
    @(negedge clk);
`ifdef CONV_RELU_EN
    chk("t5_signed", 32'(s_out_data), 32'h0);
`else
    chk("t5_signed", 32'(s_out_data), 32'hFFFEE);
`endif
    chk("t5_s_valid",   32'(s_out_valid), 32'd1);
    chk("t5_unsigned",  32'(out_data),    32'd4590);
    cyc(); cyc();

    // Reset after 4 taps of a window
    load_w(1, 1, 9);
    for (int i = 0; i < 4; i++) send_in(8'd1);
    rst_n = 1'b1;
    cyc();
    rst_n = 1'b0;
    @(negedge clk);
    chk("t6_out_valid", 32'(out_valid), 32'd0);
    chk("t6_wt_loaded", 32'(wt_loaded), 32'd0);
    chk("t6_in_ready",  32'(in_ready),  32'd0);
    chk("t6_w_ready",   32'(w_ready),   32'd1);
    cyc();
    load_w(1, 1, 9);
    window(8'd1, 1'b0);
    @(negedge clk);
    chk("t6_result", 32'(out_data), 32'd45);
    chk("t6_valid",  32'(out_valid), 32'd1);
    cyc(); cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
